// File: rtl/pe_pkg.sv
// Shared types and address helper for the PE operand read masters.
package pe_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_COLLECT,
    RD_DONE
  } rd_state_t;

  // Wide enough for any word address / base combination; callers truncate to the bus width.
  localparam int unsigned CALC_W = 64;

  function automatic logic [CALC_W-1:0] byte_addr(input logic [CALC_W-1:0] base,
                                                  input logic [CALC_W-1:0] word,
                                                  input int unsigned       shift);
    return base + (word << shift);
  endfunction

endpackage

// File: rtl/pe_operand_read_master.sv
// Avalon-MM burst read master: one BURST_LEN-beat operand per PE request, 4 cycles request->pulse unstalled.
// waitrequest holds the read; one extra request waits in a pending slot (latest wins, sets overrun).
module pe_operand_read_master
  import pe_pkg::*;
#(
  parameter int unsigned           ADDR_IN_W  = 11,
  parameter int unsigned           DATA_W     = 128,
  parameter int unsigned           BURST_LEN  = 2,
  parameter int unsigned           AVM_ADDR_W = 32,
  parameter logic [AVM_ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        master_en,
  input  logic [ADDR_IN_W-1:0]        addr_in,
  output logic [AVM_ADDR_W-1:0]       avm_address,
  output logic                        avm_read,
  output logic [$clog2(BURST_LEN):0]  avm_burstcount,
  input  logic                        avm_waitrequest,
  input  logic [DATA_W-1:0]           avm_readdata,
  input  logic                        avm_readdatavalid,
  output logic [DATA_W*BURST_LEN-1:0] pe_data,
  output logic                        readdatavalid_out,
  output logic                        busy,
  output logic                        overrun
);

  localparam int unsigned BC_W  = $clog2(BURST_LEN) + 1;
  localparam int unsigned SHIFT = $clog2(DATA_W / 8);
  localparam int unsigned PE_W  = DATA_W * BURST_LEN;

  rd_state_t              state_q, state_d;
  logic                   en_prev_q;
  logic [ADDR_IN_W-1:0]   last_addr_q, last_addr_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [ADDR_IN_W-1:0]   pend_addr_q, pend_addr_d;
  logic                   overrun_q, overrun_d;
  logic [AVM_ADDR_W-1:0]  avm_address_q, avm_address_d;
  logic [BC_W-1:0]        beat_q, beat_d;
  logic [PE_W-1:0]        asm_q, asm_d;
  logic [PE_W-1:0]        pe_data_q, pe_data_d;
  logic                   new_req, last_beat, do_issue;
  logic [ADDR_IN_W-1:0]   issue_addr;

  assign new_req     = master_en && (!en_prev_q || (addr_in != last_addr_q));
  assign last_beat   = (beat_q == BC_W'(BURST_LEN - 1));
  assign last_addr_d = new_req ? addr_in : last_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:    if (new_req || pend_vld_q) state_d = RD_ISSUE;
      RD_ISSUE:   if (!avm_waitrequest) state_d = RD_COLLECT;
      RD_COLLECT: if (avm_readdatavalid && last_beat) state_d = RD_DONE;
      RD_DONE:    state_d = pend_vld_q ? RD_ISSUE : RD_IDLE;
      default:    state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    avm_read          = (state_q == RD_ISSUE);
    readdatavalid_out = (state_q == RD_DONE);
    busy              = (state_q != RD_IDLE) || pend_vld_q;
  end

  // A request arriving in IDLE always wins over an older pending one.
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    overrun_d   = overrun_q;
    do_issue    = 1'b0;
    issue_addr  = addr_in;
    unique case (state_q)
      RD_IDLE: begin
        if (new_req) begin
          do_issue   = 1'b1;
          overrun_d  = overrun_q | pend_vld_q;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          do_issue   = 1'b1;
          issue_addr = pend_addr_q;
          pend_vld_d = 1'b0;
        end
      end
      RD_DONE: begin
        if (pend_vld_q) begin
          do_issue   = 1'b1;
          issue_addr = pend_addr_q;
          pend_vld_d = 1'b0;
        end
        if (new_req) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = addr_in;
        end
      end
      default: begin
        if (new_req) begin
          overrun_d   = overrun_q | pend_vld_q;
          pend_vld_d  = 1'b1;
          pend_addr_d = addr_in;
        end
      end
    endcase
    avm_address_d = avm_address_q;
    if (do_issue)
      avm_address_d = AVM_ADDR_W'(byte_addr(CALC_W'(BASE_ADDR), CALC_W'(issue_addr), SHIFT));
  end

  always_comb begin
    beat_d    = beat_q;
    asm_d     = asm_q;
    pe_data_d = pe_data_q;
    if ((state_q == RD_COLLECT) && avm_readdatavalid) begin
      for (int b = 0; b < BURST_LEN; b++) begin
        if (beat_q == BC_W'(b)) asm_d[b*DATA_W +: DATA_W] = avm_readdata;
      end
      if (last_beat) begin
        pe_data_d = asm_d;
        beat_d    = '0;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
    if (state_q == RD_DONE) beat_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_prev_q     <= 1'b0;
      last_addr_q   <= '0;
      pend_vld_q    <= 1'b0;
      pend_addr_q   <= '0;
      overrun_q     <= 1'b0;
      avm_address_q <= '0;
      beat_q        <= '0;
      asm_q         <= '0;
      pe_data_q     <= '0;
    end else begin
      en_prev_q     <= master_en;
      last_addr_q   <= last_addr_d;
      pend_vld_q    <= pend_vld_d;
      pend_addr_q   <= pend_addr_d;
      overrun_q     <= overrun_d;
      avm_address_q <= avm_address_d;
      beat_q        <= beat_d;
      asm_q         <= asm_d;
      pe_data_q     <= pe_data_d;
    end
  end

  assign avm_address    = avm_address_q;
  assign avm_burstcount = BC_W'(BURST_LEN);
  assign pe_data        = pe_data_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_pe_operand_read_master.sv
// Bench for pe_operand_read_master: directed scenarios plus a randomized phase against a memory/scoreboard model.
module tb_pe_operand_read_master;

  localparam int ADDR_IN_W  = 11;
  localparam int DATA_W     = 128;
  localparam int BURST_LEN  = 2;
  localparam int AVM_ADDR_W = 32;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        master_en = 1'b0;
  logic [ADDR_IN_W-1:0]        addr_in = '0;
  logic [AVM_ADDR_W-1:0]       avm_address;
  logic                        avm_read;
  logic [1:0]                  avm_burstcount;
  logic                        avm_waitrequest = 1'b0;
  logic [DATA_W-1:0]           avm_readdata = '0;
  logic                        avm_readdatavalid = 1'b0;
  logic [DATA_W*BURST_LEN-1:0] pe_data;
  logic                        readdatavalid_out;
  logic                        busy;
  logic                        overrun;

  pe_operand_read_master #(
    .ADDR_IN_W(ADDR_IN_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
    .AVM_ADDR_W(AVM_ADDR_W), .BASE_ADDR('0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .master_en(master_en), .addr_in(addr_in),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .pe_data(pe_data),
    .readdatavalid_out(readdatavalid_out), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Memory contents are a fixed function of the word address.
  function automatic logic [127:0] mem_word(input logic [31:0] w);
    return {w * 32'h9E37_79B1, ~w, w ^ 32'hA5A5_5A5A, 32'hC0DE_0000 + w};
  endfunction

  function automatic logic [255:0] operand(input logic [31:0] w);
    return {mem_word(w + 32'd1), mem_word(w)};
  endfunction

  // Slave and scoreboard configuration (written only by the stimulus process).
  int stall_n = 0;
  bit rand_mode = 0;
  bit gap_mode = 0;
  int stray_total = 0;

  // Slave and scoreboard state (written only by the bus process).
  logic [127:0] beat_fifo[$];
  logic [255:0] exp_q[$];
  logic [31:0]  acc_addr[$];
  int           pulse_cnt = 0;
  int           last_pulse_cyc = -1;
  int           stray_done = 0;
  int           wcnt = 0;
  int           cur_stall = 0;

  always @(negedge clk) begin
    logic w;
    if (!rst_n) begin
      exp_q.delete();
    end else if (readdatavalid_out) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      chk("pulse_has_expect", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) chk("pe_data", pe_data, exp_q.pop_front());
    end

    if (beat_fifo.size() > 0 && (!gap_mode || $urandom_range(0, 2) != 0)) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = beat_fifo.pop_front();
    end else if (beat_fifo.size() == 0 && stray_done < stray_total) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = {4{$urandom()}};
      stray_done++;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = {4{$urandom()}};
    end

    if (avm_read && rst_n) begin
      if (wcnt == 0) cur_stall = rand_mode ? int'($urandom_range(0, 3)) : stall_n;
      w = (wcnt < cur_stall);
      wcnt++;
    end else begin
      w    = 1'b0;
      wcnt = 0;
    end
    avm_waitrequest = w;

    if (avm_read && !w && rst_n) begin
      acc_addr.push_back(avm_address);
      for (int k = 0; k < BURST_LEN; k++)
        beat_fifo.push_back(mem_word((avm_address >> 4) + 32'(k)));
      exp_q.push_back(operand(avm_address >> 4));
      wcnt = 0;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    cyc_wait(2);
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 256'(busy), 256'(0));
    cyc_wait(1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_avm_read"}, 256'(avm_read), 256'(0));
    chk({pfx, "_avm_address"}, 256'(avm_address), 256'(0));
    chk({pfx, "_pe_data"}, pe_data, 256'(0));
    chk({pfx, "_rdv_out"}, 256'(readdatavalid_out), 256'(0));
    chk({pfx, "_busy"}, 256'(busy), 256'(0));
    chk({pfx, "_overrun"}, 256'(overrun), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_req, p0, a0, r, nreq;
    logic [ADDR_IN_W-1:0] last_req;
    logic prev_en;
    bit requested[2048];

    // Reset state
    cyc_wait(3);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc_wait(2);

    // 1: single request, no stalls
    p0 = pulse_cnt;
    master_en = 1'b1;
    addr_in = 11'd5;
    t_req = cyc;
    @(negedge clk);
    chk("t1_avm_read", 256'(avm_read), 256'(1));
    chk("t1_avm_address", 256'(avm_address), 256'(32'h50));
    chk("t1_burstcount", 256'(avm_burstcount), 256'(2));
    cyc_wait(6);
    chk("t1_pulses", 256'(pulse_cnt - p0), 256'(1));
    chk("t1_latency", 256'(last_pulse_cyc - t_req), 256'(4));
    chk("t1_pe_data", pe_data, {mem_word(32'd6), mem_word(32'd5)});
    master_en = 1'b0;
    wait_idle("t1_idle");

    // 2: waitrequest held for 3 cycles
    stall_n = 3;
    p0 = pulse_cnt;
    a0 = acc_addr.size();
    master_en = 1'b1;
    addr_in = 11'd12;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_read_hold", 256'(avm_read), 256'(1));
      chk("t2_addr_hold", 256'(avm_address), 256'(12 * 16));
    end
    @(negedge clk);
    chk("t2_read_drop", 256'(avm_read), 256'(0));
    cyc_wait(8);
    chk("t2_pulses", 256'(pulse_cnt - p0), 256'(1));
    chk("t2_issues", 256'(acc_addr.size() - a0), 256'(1));
    master_en = 1'b0;
    stall_n = 0;
    wait_idle("t2_idle");

    // 3: address stepped every 2 cycles
    p0 = pulse_cnt;
    a0 = acc_addr.size();
    master_en = 1'b1;
    addr_in = 11'd0;
    cyc_wait(2);
    addr_in = 11'd2;
    cyc_wait(2);
    addr_in = 11'd4;
    cyc_wait(20);
    chk("t3_pulses", 256'(pulse_cnt - p0), 256'(3));
    chk("t3_issues", 256'(acc_addr.size() - a0), 256'(3));
    if (acc_addr.size() >= a0 + 3) begin
      for (int i = 0; i < 3; i++) chk("t3_order", 256'(acc_addr[a0 + i]), 256'(i * 32));
    end
    chk("t3_overrun", 256'(overrun), 256'(0));
    master_en = 1'b0;
    wait_idle("t3_idle");

    // 4: requests pile up behind a stalled burst
    stall_n = 8;
    p0 = pulse_cnt;
    a0 = acc_addr.size();
    master_en = 1'b1;
    addr_in = 11'd20;
    cyc_wait(2);
    addr_in = 11'd30;
    cyc_wait(1);
    addr_in = 11'd40;
    cyc_wait(1);
    chk("t4_overrun_set", 256'(overrun), 256'(1));
    cyc_wait(30);
    chk("t4_pulses", 256'(pulse_cnt - p0), 256'(2));
    chk("t4_issues", 256'(acc_addr.size() - a0), 256'(2));
    if (acc_addr.size() >= a0 + 2) begin
      chk("t4_first", 256'(acc_addr[a0]), 256'(20 * 16));
      chk("t4_latest", 256'(acc_addr[a0 + 1]), 256'(40 * 16));
    end
    chk("t4_overrun_sticky", 256'(overrun), 256'(1));
    master_en = 1'b0;
    stall_n = 0;
    wait_idle("t4_idle");

    // 5: reset while collecting, after one beat
    master_en = 1'b1;
    addr_in = 11'd9;
    cyc_wait(3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    master_en = 1'b0;
    cyc_wait(2);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    a0 = acc_addr.size();
    stray_total = stray_total + 3;
    cyc_wait(10);
    chk("t5_no_pulse", 256'(pulse_cnt - p0), 256'(0));
    chk("t5_no_issue", 256'(acc_addr.size() - a0), 256'(0));
    chk("t5_busy", 256'(busy), 256'(0));

    // 6: enable held with a constant address
    p0 = pulse_cnt;
    a0 = acc_addr.size();
    master_en = 1'b1;
    addr_in = 11'd33;
    cyc_wait(10);
    chk("t6_issues", 256'(acc_addr.size() - a0), 256'(1));
    master_en = 1'b0;
    wait_idle("t6_idle");
    chk("t6_pulses", 256'(pulse_cnt - p0), 256'(1));

    // Randomized phase: random stalls, beat gaps, enable toggles and address changes
    rand_mode = 1;
    gap_mode = 1;
    p0 = pulse_cnt;
    a0 = acc_addr.size();
    prev_en = 1'b0;
    last_req = 11'd33;
    nreq = 0;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) master_en = ~master_en;
      else if (r < 5) addr_in = 11'($urandom_range(0, 63));
      if (master_en && (!prev_en || addr_in != last_req)) begin
        requested[addr_in] = 1'b1;
        last_req = addr_in;
        nreq++;
      end
      prev_en = master_en;
      @(negedge clk);
    end
    master_en = 1'b0;
    wait_idle("rnd_idle");
    for (int i = a0; i < acc_addr.size(); i++)
      chk("rnd_issue_was_requested",
          256'(requested[acc_addr[i][14:4]] && acc_addr[i][3:0] == 4'd0 && acc_addr[i][31:15] == '0),
          256'(1));
    chk("rnd_pulses_eq_issues", 256'(pulse_cnt - p0), 256'(acc_addr.size() - a0));
    chk("rnd_scoreboard_empty", 256'(exp_q.size()), 256'(0));
    if (nreq > 0 && acc_addr.size() > a0)
      chk("rnd_latest_served", 256'(acc_addr[acc_addr.size() - 1]), 256'(32'(last_req) * 16));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
